// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared types and encodings for the 8-bit CPU control sequencer.
package cpu_ctrl_fsm_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    typedef logic [1:0] opcode_t;

    localparam opcode_t OpAddi = 2'b00;
    localparam opcode_t OpLd   = 2'b01;
    localparam opcode_t OpSt   = 2'b10;
    localparam opcode_t OpJmp  = 2'b11;

    localparam logic [5:0] HaltImm = 6'h3F;

    localparam logic [1:0] InselImm3 = 2'b00;
    localparam logic [1:0] InselImm6 = 2'b01;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluPassB = 2'b01;

    // A jump to the all-ones offset is the halt encoding.
    function automatic logic is_halt(input logic [7:0] ir);
        return (ir[7:6] == OpJmp) && (ir[5:0] == HaltImm);
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_ack_timer.sv
// Counts unacknowledged request cycles; flags expiry in the cycle the limit is reached.
module ack_timer #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic ack_i,
    output logic expired_o
);

    localparam int unsigned TimerW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int unsigned Limit  = (ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1;

    logic [TimerW-1:0] timer_q, timer_d;

    // timer_q holds the number of earlier waiting cycles, so the current cycle is timer_q+1.
    assign expired_o = (ACK_TIMEOUT != 0) && req_i && !ack_i && (timer_q == TimerW'(Limit));

    always_comb begin
        timer_d = '0;
        if (req_i && !ack_i && !expired_o) begin
            timer_d = timer_q + TimerW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute sequencer driving the 8-bit datapath strobes.
module cpu_ctrl_fsm
    import cpu_ctrl_fsm_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [7:0]       instr_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             ir_en_o,
    output logic             pc_en_o,
    output logic             pc_sel_o,
    output logic [1:0]       insel_o,
    output logic [1:0]       alu_op_o,
    output logic             reg_we_o,
    output logic             busy_o,
    output logic             halted_o,
    output logic             err_o,
    output logic [CNT_W-1:0] icount_o
);

    state_e           state_q, state_d;
    logic [7:0]       ir_q, ir_d;
    logic [CNT_W-1:0] icount_q, icount_d;
    logic             err_q, err_d;
    logic             retire;
    logic             expired;
    opcode_t          op;

    assign op = ir_q[7:6];

    ack_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_ack_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (mem_req_o),
        .ack_i    (mem_ack_i),
        .expired_o(expired)
    );

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        err_d     = err_q;
        retire    = 1'b0;
        mem_req_o = 1'b0;
        mem_we_o  = 1'b0;
        ir_en_o   = 1'b0;
        pc_en_o   = 1'b0;
        pc_sel_o  = 1'b0;
        insel_o   = InselImm3;
        alu_op_o  = AluAdd;
        reg_we_o  = 1'b0;
        halted_o  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    ir_en_o = 1'b1;
                    pc_en_o = 1'b1;
                    ir_d    = instr_i;
                    state_d = StDecode;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = StHalt;
                end
            end
            StDecode: begin
                state_d = StExec;
            end
            StExec: begin
                unique case (op)
                    OpAddi: begin
                        insel_o  = InselImm3;
                        alu_op_o = AluAdd;
                        state_d  = StWb;
                    end
                    OpLd, OpSt: begin
                        alu_op_o = AluPassB;
                        state_d  = StMem;
                    end
                    OpJmp: begin
                        retire = 1'b1;
                        if (is_halt(ir_q)) begin
                            state_d = StHalt;
                        end else begin
                            insel_o  = InselImm6;
                            pc_sel_o = 1'b1;
                            pc_en_o  = 1'b1;
                            state_d  = StFetch;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
            StMem: begin
                mem_req_o = 1'b1;
                mem_we_o  = (op == OpSt);
                if (mem_ack_i) begin
                    if (op == OpSt) begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = StHalt;
                end
            end
            StWb: begin
                reg_we_o = 1'b1;
                retire   = 1'b1;
                state_d  = StFetch;
            end
            StHalt: begin
                halted_o = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        icount_d = icount_q;
        if (retire) begin
            icount_d = icount_q + CNT_W'(1);
        end
    end

    assign busy_o   = (state_q != StIdle) && (state_q != StHalt);
    assign err_o    = err_q;
    assign icount_o = icount_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            ir_q     <= '0;
            icount_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            icount_q <= icount_d;
            err_q    <= err_d;
        end
    end

endmodule
